// File: rtl/key_search_scheduler.sv
// key_search_scheduler: round-robin block dispatcher for the RC4 key-search core array with found/exhaustion detection
module key_search_scheduler #(
  parameter int               N_CORES    = 4,
  parameter int               KEY_W      = 24,
  parameter logic [KEY_W-1:0] KEY_MAX    = 24'h3FFFFF,
  parameter int               BLOCK_LOG2 = 8,
  localparam int              CW         = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [N_CORES-1:0]       core_req,
  input  logic [N_CORES-1:0]       core_found,
  input  logic [N_CORES*KEY_W-1:0] core_key,
  output logic [N_CORES-1:0]       core_grant,
  output logic [KEY_W-1:0]         grant_base,
  output logic                     core_abort,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [KEY_W-1:0]         found_key,
  output logic [CW-1:0]            found_core
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [KEY_W:0] BLK = (KEY_W+1)'(1) << BLOCK_LOG2;
  state_t             state_q, state_d;
  logic [KEY_W:0]     next_base_q, next_base_d;
  logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [N_CORES-1:0] core_grant_q, core_grant_d;
  logic [KEY_W-1:0]   grant_base_q, grant_base_d;
  logic               core_abort_q, core_abort_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic [KEY_W-1:0]   found_key_q, found_key_d;
  logic [CW-1:0]      found_core_q, found_core_d;
  logic [N_CORES-1:0] elig;
  logic               win_v, avail;
  logic [CW-1:0]      win, fc;
  logic [CW:0]        idx;
  logic [KEY_W-1:0]   fk;
  // last grant doubles as the outstanding mask, hiding each core's req-drop latency
  always_comb begin
    elig  = core_req & ~core_grant_q;
    win_v = 1'b0;
    win   = '0;
    idx   = '0;
    for (int j = N_CORES - 1; j >= 0; j--) begin
      idx = {1'b0, rr_ptr_q} + (CW+1)'(j);
      if (idx >= (CW+1)'(N_CORES)) idx = idx - (CW+1)'(N_CORES);
      if (elig[idx[CW-1:0]]) begin
        win_v = 1'b1;
        win   = idx[CW-1:0];
      end
    end
  end
  always_comb begin
    fc = '0;
    fk = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        fc = CW'(i);
        fk = core_key[i*KEY_W +: KEY_W];
      end
    end
  end
  always_comb begin
    state_d      = state_q;
    next_base_d  = next_base_q;
    rr_ptr_d     = rr_ptr_q;
    core_grant_d = '0;
    grant_base_d = '0;
    core_abort_d = core_abort_q;
    found_d      = found_q;
    found_key_d  = found_key_q;
    found_core_d = found_core_q;
    avail        = next_base_q <= {1'b0, KEY_MAX};
    if (state_q != RUN) begin
      if (start) begin
        state_d      = RUN;
        next_base_d  = '0;
        rr_ptr_d     = '0;
        core_abort_d = 1'b0;
        found_d      = 1'b0;
        found_key_d  = '0;
        found_core_d = '0;
      end
    end else if (|core_found) begin
      state_d      = DONE;
      found_d      = 1'b1;
      core_abort_d = 1'b1;
      found_key_d  = fk;
      found_core_d = fc;
    end else if (!avail && &core_req) begin
      state_d      = DONE;
      core_abort_d = 1'b1;
    end else if (avail && win_v) begin
      core_grant_d[win] = 1'b1;
      grant_base_d      = next_base_q[KEY_W-1:0];
      next_base_d       = next_base_q + BLK;
      rr_ptr_d          = (win == CW'(N_CORES - 1)) ? '0 : win + CW'(1);
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      next_base_q  <= '0;
      rr_ptr_q     <= '0;
      core_grant_q <= '0;
      grant_base_q <= '0;
      core_abort_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      found_key_q  <= '0;
      found_core_q <= '0;
    end else begin
      state_q      <= state_d;
      next_base_q  <= next_base_d;
      rr_ptr_q     <= rr_ptr_d;
      core_grant_q <= core_grant_d;
      grant_base_q <= grant_base_d;
      core_abort_q <= core_abort_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      found_key_q  <= found_key_d;
      found_core_q <= found_core_d;
    end
  end
  assign core_grant = core_grant_q;
  assign grant_base = grant_base_q;
  assign core_abort = core_abort_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign found_key  = found_key_q;
  assign found_core = found_core_q;
endmodule
